host_data_loader: RTL and testbench

- Host-to-FPGA loader: receiver counterpart of interpreter_comunication, which streams data memory out.
- Accepts a byte stream from the interpreter link over a valid/ready handshake.
- Parses a framed load command and packs bytes into R-lane vector words.
- Writes the words into data_mem through its WE/A/WD port, muxed with the cpu at top level.
- load_busy is intended to drive cpu pause so the CPU is held while memory is rewritten.

---
 rtl/host_data_loader_pkg.sv | 25 ++
 rtl/host_data_loader_vec_packer.sv | 52 +++++
 rtl/host_data_loader.sv | 192 +++++++++++++++++++
 tb/tb_host_data_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/host_data_loader_pkg.sv
// Shared loader constants and types (package top_params).
// The checksum build option is HOST_LOADER_CHECKSUM_EN.
package top_params;

    localparam int unsigned LOADER_I  = 32;
    localparam int unsigned LOADER_N  = 8;
    localparam int unsigned LOADER_R  = 6;
    localparam int unsigned DMEM_SIZE = 10926;

    localparam logic [7:0] LOADER_SYNC = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StAddrLo,
        StAddrHi,
        StCntLo,
        StCntHi,
        StPayload,
        StCheck,
        StDone
    } loader_state_t;

    typedef logic [LOADER_R-1:0][LOADER_N-1:0] vec_word_t;

endpackage

// File: rtl/host_data_loader_vec_packer.sv
// Byte-to-lane packer. Byte k of each word lands in lane k.
// word_ready and word show the completed word in the same cycle as its last byte.
module vec_packer #(
    parameter int unsigned N = 8,
    parameter int unsigned R = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                byte_valid,
    input  logic [N-1:0]        byte_in,
    output logic                word_ready,
    output logic [R-1:0][N-1:0] word
);

    localparam int unsigned CntW = (R > 1) ? $clog2(R) : 1;

    logic [CntW-1:0]       lane_q, lane_d;
    logic [R-1:0][N-1:0]   word_q, word_d;

    always_comb begin
        lane_d     = lane_q;
        word_d     = word_q;
        word_ready = 1'b0;
        if (clear) begin
            lane_d = '0;
            word_d = '0;
        end else if (byte_valid) begin
            word_d[lane_q] = byte_in;
            if (lane_q == CntW'(R - 1)) begin
                word_ready = 1'b1;
                lane_d     = '0;
            end else begin
                lane_d = lane_q + CntW'(1);
            end
        end
    end

    // Downstream captures the inserted word, not the stale packing register.
    assign word = word_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q <= '0;
            word_q <= '0;
        end else begin
            lane_q <= lane_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/host_data_loader.sv
// Host-to-data-memory loader: parses framed byte stream, packs R-lane words, writes data_mem.
// Define HOST_LOADER_CHECKSUM_EN to add the trailing XOR checksum byte and CHECK state.
module host_data_loader
    import top_params::*;
#(
    parameter int unsigned I         = LOADER_I,
    parameter int unsigned N         = LOADER_N,
    parameter int unsigned R         = LOADER_R,
    parameter int unsigned DMEM_SIZE = top_params::DMEM_SIZE,
    parameter logic [N-1:0] SYNC_BYTE = LOADER_SYNC
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [N-1:0]        in_data,
    output logic                in_ready,
    output logic                mem_we,
    output logic [I-1:0]        mem_addr,
    output logic [R-1:0][N-1:0] mem_wd,
    output logic                load_busy,
    output logic                load_done,
    output logic                load_err
);

`ifdef HOST_LOADER_CHECKSUM_EN
    localparam loader_state_t StAfterData = StCheck;
`else
    localparam loader_state_t StAfterData = StDone;
`endif

    loader_state_t       state_q, state_d;
    logic [15:0]         addr_q, addr_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [15:0]         idx_q, idx_d;
    logic                range_bad_q, range_bad_d;
    logic                err_q, err_d;
    logic                we_q, we_d;
    logic [I-1:0]        maddr_q, maddr_d;
    logic [R-1:0][N-1:0] wd_q, wd_d;
`ifdef HOST_LOADER_CHECKSUM_EN
    logic [N-1:0]        chk_q, chk_d;
`endif

    logic                accept;
    logic                pk_clear, pk_valid, pk_ready;
    logic [R-1:0][N-1:0] pk_word;
    logic [16:0]         end_addr;
    logic                range_over;

    assign in_ready = ~reset & (state_q != StDone);
    assign accept   = in_valid & in_ready;

    vec_packer #(
        .N (N),
        .R (R)
    ) u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (pk_clear),
        .byte_valid (pk_valid),
        .byte_in    (in_data),
        .word_ready (pk_ready),
        .word       (pk_word)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        range_bad_d = range_bad_q;
        err_d       = err_q;
        we_d        = 1'b0;
        maddr_d     = maddr_q;
        wd_d        = wd_q;
        pk_clear    = 1'b0;
        pk_valid    = 1'b0;
        // 17-bit sum so a start near 0xFFFF cannot wrap below DMEM_SIZE.
        end_addr    = {1'b0, addr_q} + {1'b0, in_data, cnt_q[7:0]};
        range_over  = {15'd0, end_addr} > DMEM_SIZE;
`ifdef HOST_LOADER_CHECKSUM_EN
        chk_d       = chk_q;
`endif

        case (state_q)
            StIdle: begin
                if (accept && in_data == SYNC_BYTE) begin
                    state_d     = StAddrLo;
                    err_d       = 1'b0;
                    range_bad_d = 1'b0;
                    pk_clear    = 1'b1;
`ifdef HOST_LOADER_CHECKSUM_EN
                    chk_d       = '0;
`endif
                end
            end
            StAddrLo: if (accept) begin
                addr_d[7:0] = in_data;
                state_d     = StAddrHi;
            end
            StAddrHi: if (accept) begin
                addr_d[15:8] = in_data;
                state_d      = StCntLo;
            end
            StCntLo: if (accept) begin
                cnt_d[7:0] = in_data;
                state_d    = StCntHi;
            end
            StCntHi: if (accept) begin
                cnt_d[15:8] = in_data;
                idx_d       = '0;
                range_bad_d = range_over;
                if ({in_data, cnt_q[7:0]} == 16'd0) begin
                    state_d = StAfterData;
`ifndef HOST_LOADER_CHECKSUM_EN
                    err_d   = range_over;
`endif
                end else begin
                    state_d = StPayload;
                end
            end
            StPayload: if (accept) begin
                pk_valid = 1'b1;
                if (pk_ready) begin
                    we_d    = ~range_bad_q;
                    maddr_d = I'(addr_q) + I'(idx_q);
                    wd_d    = pk_word;
                    idx_d   = idx_q + 16'd1;
                    if (idx_q == cnt_q - 16'd1) begin
                        state_d = StAfterData;
`ifndef HOST_LOADER_CHECKSUM_EN
                        err_d   = range_bad_q;
`endif
                    end
                end
            end
`ifdef HOST_LOADER_CHECKSUM_EN
            StCheck: if (accept) begin
                err_d   = range_bad_q | (in_data != chk_q);
                state_d = StDone;
            end
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

`ifdef HOST_LOADER_CHECKSUM_EN
        // Checksum covers ADDR_LO through the last payload byte.
        if (accept && state_q inside {StAddrLo, StAddrHi, StCntLo, StCntHi, StPayload}) begin
            chk_d = chk_q ^ in_data;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            range_bad_q <= 1'b0;
            err_q       <= 1'b0;
            we_q        <= 1'b0;
            maddr_q     <= '0;
            wd_q        <= '0;
`ifdef HOST_LOADER_CHECKSUM_EN
            chk_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            range_bad_q <= range_bad_d;
            err_q       <= err_d;
            we_q        <= we_d;
            maddr_q     <= maddr_d;
            wd_q        <= wd_d;
`ifdef HOST_LOADER_CHECKSUM_EN
            chk_q       <= chk_d;
`endif
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = maddr_q;
    assign mem_wd    = wd_q;
    assign load_busy = (state_q != StIdle);
    assign load_done = (state_q == StDone);
    assign load_err  = err_q;

endmodule

// File: tb/tb_host_data_loader.sv
// Directed bench for host_data_loader: per-cycle vector table for a basic frame,
// then hand-written frames for range error, zero count, mid-frame reset, noise and checksum.
module tb_host_data_loader;

    localparam int unsigned R = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [5:0][7:0] mem_wd;
    logic        load_busy;
    logic        load_done;
    logic        load_err;

    host_data_loader dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wd    (mem_wd),
        .load_busy (load_busy),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        we;
        logic [31:0] addr;
        logic [47:0] wd;
        logic        busy;
        logic        done;
        logic        err;
        logic        rdy;
    } vec_t;

    vec_t        tbl [40];
    int          n_tbl = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          done_cnt;
    int          done_cyc;
    int          last_byte_cyc;
    logic        err_at_done;
    logic [31:0] wr_addr [$];
    logic [47:0] wr_data [$];
    logic [7:0]  fq [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic we, input logic [31:0] a,
                       input logic [47:0] wd, input logic busy, input logic done,
                       input logic err, input logic rdy);
        tbl[n_tbl] = '{v, d, we, a, wd, busy, done, err, rdy};
        n_tbl++;
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
        cyc++;
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wd);
        end
        if (load_done) begin
            done_cnt++;
            err_at_done = load_err;
            done_cyc    = cyc;
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        done_cnt    = 0;
        err_at_done = 1'b0;
        done_cyc    = -1;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit gap);
        int w = 0;
        while (!in_ready && w < 8) begin
            step(1'b0, 8'h00);
            w++;
        end
        if (!in_ready) check("ready_wait", 64'(in_ready), 64'd1);
        step(1'b1, d);
        last_byte_cyc = cyc;
        if (gap) step(1'b0, 8'hEE);
    endtask

    task automatic build(input logic [15:0] a, input logic [15:0] c, input logic [7:0] first,
                         input bit chk_flip);
        logic [7:0] x;
        fq.delete();
        fq.push_back(8'hA5);
        fq.push_back(a[7:0]);
        fq.push_back(a[15:8]);
        fq.push_back(c[7:0]);
        fq.push_back(c[15:8]);
        for (int i = 0; i < int'(c) * R; i++) fq.push_back(8'(int'(first) + i));
        x = 8'h00;
        for (int j = 1; j < fq.size(); j++) x = x ^ fq[j];
`ifdef HOST_LOADER_CHECKSUM_EN
        fq.push_back(x ^ {7'd0, chk_flip});
`else
        if (chk_flip) x = ~x;
`endif
    endtask

    task automatic send_frame(input bit gap);
        for (int j = 0; j < fq.size(); j++) send_byte(fq[j], gap);
        for (int k = 0; k < 8 && done_cnt == 0; k++) step(1'b0, 8'h00);
        step(1'b0, 8'h00);
    endtask

    task automatic expect_writes(input string tag, input logic [15:0] a, input int words,
                                 input logic [7:0] first);
        logic [47:0] e;
        check({tag, "_nwr"}, 64'(wr_addr.size()), 64'(words));
        for (int w = 0; w < words && w < wr_addr.size(); w++) begin
            for (int k = 0; k < R; k++) e[k*8 +: 8] = 8'(int'(first) + w * R + k);
            check($sformatf("%s_addr%0d", tag, w), 64'(wr_addr[w]), 64'(32'(a) + 32'(w)));
            check($sformatf("%s_wd%0d", tag, w), 64'(wr_data[w]), 64'(e));
        end
    endtask

    task automatic pulse_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ctl", 64'({mem_we, load_busy, load_done, load_err, in_ready}), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_wd", 64'(mem_wd), 64'd0);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        clear_log();
        @(posedge clk);
        pulse_reset();

        // Basic frame: start 16, two words, payload 01..0C.
        add(1, 8'hA5, 0, 0, 0, 1, 0, 0, 1);
        add(1, 8'h10, 0, 0, 0, 1, 0, 0, 1);
        add(1, 8'h00, 0, 0, 0, 1, 0, 0, 1);
        add(1, 8'h02, 0, 0, 0, 1, 0, 0, 1);
        add(1, 8'h00, 0, 0, 0, 1, 0, 0, 1);
        for (int k = 1; k <= 5; k++) add(1, 8'(k), 0, 0, 0, 1, 0, 0, 1);
        add(1, 8'h06, 1, 32'd16, 48'h060504030201, 1, 0, 0, 1);
        for (int k = 7; k <= 11; k++) add(1, 8'(k), 0, 0, 0, 1, 0, 0, 1);
`ifdef HOST_LOADER_CHECKSUM_EN
        add(1, 8'h0C, 1, 32'd17, 48'h0C0B0A090807, 1, 0, 0, 1);
        add(1, 8'h1E, 0, 0, 0, 1, 1, 0, 0);
`else
        add(1, 8'h0C, 1, 32'd17, 48'h0C0B0A090807, 1, 1, 0, 0);
`endif
        // A5 offered during DONE is refused, so the loader stays idle afterwards.
        add(1, 8'hA5, 0, 0, 0, 0, 0, 0, 1);
        add(0, 8'h00, 0, 0, 0, 0, 0, 0, 1);

        for (int i = 0; i < n_tbl; i++) begin
            step(tbl[i].v, tbl[i].d);
            check($sformatf("row%0d_ctl", i),
                  64'({mem_we, load_busy, load_done, load_err, in_ready}),
                  64'({tbl[i].we, tbl[i].busy, tbl[i].done, tbl[i].err, tbl[i].rdy}));
            if (tbl[i].we) begin
                check($sformatf("row%0d_addr", i), 64'(mem_addr), 64'(tbl[i].addr));
                check($sformatf("row%0d_wd", i), 64'(mem_wd), 64'(tbl[i].wd));
            end
        end

        // Range overflow: end 10927 > 10926, bytes consumed, nothing written.
        clear_log();
        build(16'h2AAC, 16'd3, 8'h40, 1'b0);
        send_frame(1'b0);
        check("range_nwr", 64'(wr_addr.size()), 64'd0);
        check("range_done", 64'(done_cnt), 64'd1);
        check("range_err", 64'(err_at_done), 64'd1);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        check("err_sticky", 64'(load_err), 64'd1);
        send_byte(8'hA5, 1'b0);
        check("err_clr_sync", 64'({load_err, load_busy}), 64'b01);
        pulse_reset();

        // End exactly at DMEM_SIZE is legal.
        clear_log();
        build(16'h2AAB, 16'd3, 8'h20, 1'b0);
        send_frame(1'b0);
        expect_writes("edge", 16'h2AAB, 3, 8'h20);
        check("edge_err", 64'(err_at_done), 64'd0);

        // Zero count: done right after the last frame byte.
        clear_log();
        build(16'h0005, 16'd0, 8'h00, 1'b0);
        send_frame(1'b0);
        check("cnt0_nwr", 64'(wr_addr.size()), 64'd0);
        check("cnt0_done", 64'(done_cnt), 64'd1);
        check("cnt0_lat", 64'(done_cyc), 64'(last_byte_cyc));
        check("cnt0_err", 64'(err_at_done), 64'd0);

        // Reset after three payload bytes, then resend.
        clear_log();
        build(16'h0010, 16'd2, 8'h01, 1'b0);
        for (int j = 0; j < 8; j++) send_byte(fq[j], 1'b0);
        pulse_reset();
        step(1'b0, 8'h00);
        check("abort_nwr", 64'(wr_addr.size()), 64'd0);
        send_frame(1'b0);
        expect_writes("resend", 16'h0010, 2, 8'h01);
        check("resend_done", 64'(done_cnt), 64'd1);
        check("resend_err", 64'(err_at_done), 64'd0);

        // Noise before sync and in_valid toggling every other cycle.
        clear_log();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h12, 1'b1);
        check("noise_idle", 64'(load_busy), 64'd0);
        send_frame(1'b1);
        expect_writes("noise", 16'h0010, 2, 8'h01);
        check("noise_err", 64'(err_at_done), 64'd0);

`ifdef HOST_LOADER_CHECKSUM_EN
        clear_log();
        build(16'h0010, 16'd2, 8'h01, 1'b0);
        send_frame(1'b0);
        expect_writes("chk_ok", 16'h0010, 2, 8'h01);
        check("chk_ok_err", 64'(err_at_done), 64'd0);
        clear_log();
        build(16'h0010, 16'd2, 8'h01, 1'b1);
        send_frame(1'b0);
        expect_writes("chk_bad", 16'h0010, 2, 8'h01);
        check("chk_bad_err", 64'(err_at_done), 64'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
